// File: rtl/auth_session_ctrl_if.sv
// auth_session_ctrl_if: card/keypad, authenticator and status bundle
// for the ATM session controller.
interface auth_session_ctrl_if;
  logic        card_in;
  logic [3:0]  acc_num_in;
  logic        pin_valid;
  logic [15:0] pin_in;
  logic        activity;
  logic        logout;
  logic        unlock_req;
  logic [3:0]  unlock_idx;
  logic [3:0]  auth_acc_num;
  logic [15:0] auth_pin;
  logic [3:0]  auth_acc_index;
  logic        auth_found;
  logic        auth_ok;
  logic        session_active;
  logic [3:0]  session_index;
  logic [1:0]  tries_left;
  logic        not_found;
  logic        pin_fail;
  logic        locked;
  logic        timeout;
  logic        eject;

  modport master (
    output card_in, acc_num_in, pin_valid, pin_in,
    output activity, logout, unlock_req, unlock_idx,
    output auth_acc_index, auth_found, auth_ok,
    input  auth_acc_num, auth_pin,
    input  session_active, session_index, tries_left,
    input  not_found, pin_fail, locked, timeout, eject
  );

  modport slave (
    input  card_in, acc_num_in, pin_valid, pin_in,
    input  activity, logout, unlock_req, unlock_idx,
    input  auth_acc_index, auth_found, auth_ok,
    output auth_acc_num, auth_pin,
    output session_active, session_index, tries_left,
    output not_found, pin_fail, locked, timeout, eject
  );
endinterface

// File: rtl/auth_session_ctrl.sv
// auth_session_ctrl: ATM card session sequencer with PIN retry
// counting, account lockout and inactivity timeout.
module auth_session_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NUM_ACCOUNTS   = 10
) (
  input logic clk,
  input logic rst,
  auth_session_ctrl_if.slave bus
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [4:0] NACC = 5'(NUM_ACCOUNTS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_PIN,
    CHECK,
    ACTIVE,
    EJECT
  } state_t;

  state_t                  state;
  logic [TW-1:0]           timer;
  logic [TW-1:0]           timer_inc;
  logic [NUM_ACCOUNTS-1:0] lock;
  logic [1:0]              tries_dec;
  logic                    idx_ok;
  logic                    unlock_ok;
  logic                    acc_locked;
  logic                    in_session;
  logic                    expired;

  // Next-value helpers for the timer, retry count and lock lookup
  always_comb begin
    timer_inc  = (timer == '1) ? timer : timer + T_ONE;
    expired    = (timer == T_LAST);
    tries_dec  = bus.tries_left - 2'd1;
    idx_ok     = {1'b0, bus.auth_acc_index} < NACC;
    unlock_ok  = bus.unlock_req && ({1'b0, bus.unlock_idx} < NACC);
    acc_locked = idx_ok && lock[bus.auth_acc_index];
    in_session = (state == LOOKUP) || (state == WAIT_PIN) ||
                 (state == CHECK)  || (state == ACTIVE);
  end

  // Session FSM with registered outputs and the lock bitmap
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      timer              <= '0;
      lock               <= '0;
      bus.auth_acc_num   <= '0;
      bus.auth_pin       <= '0;
      bus.session_active <= 1'b0;
      bus.session_index  <= '0;
      bus.tries_left     <= '0;
      bus.not_found      <= 1'b0;
      bus.pin_fail       <= 1'b0;
      bus.locked         <= 1'b0;
      bus.timeout        <= 1'b0;
      bus.eject          <= 1'b0;
    end else begin
      bus.not_found <= 1'b0;
      bus.pin_fail  <= 1'b0;
      bus.locked    <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.eject     <= 1'b0;
      // a lock-set later in this block overrides this clear
      if (unlock_ok) begin
        lock[bus.unlock_idx] <= 1'b0;
      end
      if (!bus.card_in && in_session) begin
        state              <= IDLE;
        bus.session_active <= 1'b0;
        bus.auth_pin       <= '0;
        bus.tries_left     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.card_in) begin
              bus.auth_acc_num <= bus.acc_num_in;
              state            <= LOOKUP;
            end
          end
          LOOKUP: begin
            if (!bus.auth_found) begin
              bus.not_found <= 1'b1;
              bus.eject     <= 1'b1;
              bus.auth_pin  <= '0;
              state         <= EJECT;
            end else if (acc_locked) begin
              bus.locked   <= 1'b1;
              bus.eject    <= 1'b1;
              bus.auth_pin <= '0;
              state        <= EJECT;
            end else begin
              bus.session_index <= bus.auth_acc_index;
              bus.tries_left    <= TRIES_INIT;
              timer             <= '0;
              state             <= WAIT_PIN;
            end
          end
          WAIT_PIN: begin
            if (bus.pin_valid) begin
              bus.auth_pin <= bus.pin_in;
              state        <= CHECK;
            end else if (expired) begin
              bus.timeout  <= 1'b1;
              bus.eject    <= 1'b1;
              bus.auth_pin <= '0;
              state        <= EJECT;
            end else begin
              timer <= timer_inc;
            end
          end
          CHECK: begin
            if (bus.auth_ok) begin
              bus.session_active <= 1'b1;
              timer              <= '0;
              state              <= ACTIVE;
            end else if (tries_dec == 2'd0) begin
              lock[bus.session_index] <= 1'b1;
              bus.tries_left <= 2'd0;
              bus.locked     <= 1'b1;
              bus.eject      <= 1'b1;
              bus.auth_pin   <= '0;
              state          <= EJECT;
            end else begin
              bus.tries_left <= tries_dec;
              bus.pin_fail   <= 1'b1;
              timer          <= '0;
              state          <= WAIT_PIN;
            end
          end
          ACTIVE: begin
            if (bus.logout) begin
              bus.session_active <= 1'b0;
              bus.eject          <= 1'b1;
              bus.auth_pin       <= '0;
              state              <= EJECT;
            end else if (bus.activity) begin
              timer <= '0;
            end else if (expired) begin
              bus.session_active <= 1'b0;
              bus.timeout        <= 1'b1;
              bus.eject          <= 1'b1;
              bus.auth_pin       <= '0;
              state              <= EJECT;
            end else begin
              timer <= timer_inc;
            end
          end
          EJECT: begin
            bus.auth_pin <= '0;
            if (!bus.card_in) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auth_session_ctrl.sv
// tb_auth_session_ctrl: directed and randomized session checks
// against a transaction-level account/lock model.
module tb_auth_session_ctrl;

  localparam int MAX_TRIES = 3;
  localparam int TMO       = 16;
  localparam int NACC      = 10;

  localparam logic [15:0] PINS [10] = '{
    16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
    16'd6789, 16'd7890, 16'd1357, 16'd2468, 16'd9999
  };

  localparam logic [4:0] P_NF = 5'b10000;
  localparam logic [4:0] P_PF = 5'b01000;
  localparam logic [4:0] P_LK = 5'b00100;
  localparam logic [4:0] P_TO = 5'b00010;
  localparam logic [4:0] P_EJ = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   lockm [NACC];

  always #5 clk = ~clk;

  auth_session_ctrl_if bus();

  auth_session_ctrl #(
    .MAX_TRIES(MAX_TRIES),
    .TIMEOUT_CYCLES(TMO),
    .NUM_ACCOUNTS(NACC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Authenticator: account n (1..10) lives at index n-1
  always_comb begin
    bus.auth_found     = 1'b0;
    bus.auth_acc_index = 4'd0;
    bus.auth_ok        = 1'b0;
    if (bus.auth_acc_num >= 4'd1 && bus.auth_acc_num <= 4'd10) begin
      bus.auth_found     = 1'b1;
      bus.auth_acc_index = bus.auth_acc_num - 4'd1;
      bus.auth_ok = (bus.auth_pin == PINS[bus.auth_acc_num - 4'd1]);
    end
  end

  function automatic logic [4:0] pulses();
    return {bus.not_found, bus.pin_fail, bus.locked,
            bus.timeout, bus.eject};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_acc", 32'(bus.auth_acc_num), 0);
    check("rst_pin", 32'(bus.auth_pin), 0);
    check("rst_sidx", 32'(bus.session_index), 0);
    check("rst_tries", 32'(bus.tries_left), 0);
    check("rst_active", 32'(bus.session_active), 0);
    check("rst_pulses", 32'(pulses()), 0);
  endtask

  task automatic insert_to_pin(input logic [3:0] acc);
    bus.card_in    = 1'b1;
    bus.acc_num_in = acc;
    step();
    step();
    check("wait_pin_entry", 32'(pulses()), 0);
  endtask

  task automatic run_session(input logic [3:0] acc, input int np,
                             input logic [15:0] p [3],
                             input bit collide);
    bit found;
    bit granted;
    bit ended;
    int idx;
    int tries;
    found   = (acc >= 4'd1 && acc <= 4'd10);
    idx     = found ? int'(acc) - 1 : 0;
    granted = 1'b0;
    ended   = 1'b0;
    bus.card_in    = 1'b1;
    bus.acc_num_in = acc;
    step();
    check("acc_latch", 32'(bus.auth_acc_num), 32'(acc));
    check("lookup_quiet", 32'(pulses()), 0);
    step();
    if (!found) begin
      check("not_found", 32'(pulses()), 32'(P_NF | P_EJ));
      check("nf_inactive", 32'(bus.session_active), 0);
      ended = 1'b1;
    end else if (lockm[idx]) begin
      check("lookup_locked", 32'(pulses()), 32'(P_LK | P_EJ));
      ended = 1'b1;
    end else begin
      check("lookup_pulses", 32'(pulses()), 0);
      check("tries_init", 32'(bus.tries_left), MAX_TRIES);
      check("sess_idx", 32'(bus.session_index), idx);
      tries = MAX_TRIES;
      for (int k = 0; k < np && !ended; k++) begin
        bus.pin_valid = 1'b1;
        bus.pin_in    = p[k];
        step();
        bus.pin_valid = 1'b0;
        check("pin_latch", 32'(bus.auth_pin), 32'(p[k]));
        check("active_early", 32'(bus.session_active), 0);
        if (p[k] == PINS[idx]) begin
          step();
          check("granted", 32'(bus.session_active), 1);
          check("grant_pulses", 32'(pulses()), 0);
          granted = 1'b1;
          ended   = 1'b1;
        end else begin
          tries--;
          if (collide && tries == 0) begin
            bus.unlock_req = 1'b1;
            bus.unlock_idx = 4'(idx);
          end
          step();
          bus.unlock_req = 1'b0;
          if (tries == 0) begin
            check("lock_pulse", 32'(pulses()), 32'(P_LK | P_EJ));
            check("tries_zero", 32'(bus.tries_left), 0);
            lockm[idx] = 1'b1;
            ended = 1'b1;
          end else begin
            check("pin_fail", 32'(pulses()), 32'(P_PF));
            check("tries_left", 32'(bus.tries_left), tries);
          end
        end
      end
      if (granted) begin
        check("sess_idx_act", 32'(bus.session_index), idx);
        check("tries_act", 32'(bus.tries_left), tries);
        repeat ($urandom_range(0, 5)) begin
          step();
          check("hold_active", 32'(bus.session_active), 1);
        end
        bus.logout = 1'b1;
        step();
        bus.logout = 1'b0;
        check("logout_eject", 32'(pulses()), 32'(P_EJ));
        check("logout_inactive", 32'(bus.session_active), 0);
      end
    end
    if (ended) begin
      check("eject_pin_clr", 32'(bus.auth_pin), 0);
      step();
      check("eject_once", 32'(pulses()), 0);
      bus.card_in = 1'b0;
      step();
      check("eject_idle", 32'(pulses()), 0);
    end else begin
      bus.card_in = 1'b0;
      step();
      check("drop_pulses", 32'(pulses()), 0);
      check("drop_tries", 32'(bus.tries_left), 0);
      check("drop_pin", 32'(bus.auth_pin), 0);
    end
  endtask

  task automatic unlock(input logic [3:0] idx);
    bus.unlock_req = 1'b1;
    bus.unlock_idx = idx;
    step();
    bus.unlock_req = 1'b0;
    if (idx < 4'd10) lockm[idx] = 1'b0;
    check("unlock_quiet", 32'(pulses()), 0);
  endtask

  initial begin
    logic [15:0] pv [3];
    logic [3:0]  acc;
    int          np;
    rst            = 1'b1;
    bus.card_in    = 1'b0;
    bus.acc_num_in = '0;
    bus.pin_valid  = 1'b0;
    bus.pin_in     = '0;
    bus.activity   = 1'b0;
    bus.logout     = 1'b0;
    bus.unlock_req = 1'b0;
    bus.unlock_idx = '0;
    for (int i = 0; i < NACC; i++) lockm[i] = 1'b0;
    step();
    step();
    check_reset();
    rst = 1'b0;

    pv = '{16'd3456, 16'd0, 16'd0};
    run_session(4'd3, 1, pv, 1'b0);
    run_session(4'd12, 0, pv, 1'b0);

    pv = '{16'd1111, 16'd2222, 16'd3333};
    run_session(4'd5, 3, pv, 1'b0);
    pv = '{16'd5678, 16'd0, 16'd0};
    run_session(4'd5, 1, pv, 1'b0);
    unlock(4'd4);
    run_session(4'd5, 1, pv, 1'b0);

    pv = '{16'd1, 16'd2, 16'd3};
    run_session(4'd5, 3, pv, 1'b1);
    pv = '{16'd5678, 16'd0, 16'd0};
    run_session(4'd5, 1, pv, 1'b0);
    unlock(4'd14);
    unlock(4'd4);

    insert_to_pin(4'd1);
    for (int c = 1; c < TMO; c++) begin
      bus.activity = (c == 8);
      bus.logout   = (c == 9);
      step();
      check("wp_no_timeout", 32'(pulses()), 0);
    end
    bus.activity = 1'b0;
    bus.logout   = 1'b0;
    step();
    check("wp_timeout", 32'(pulses()), 32'(P_TO | P_EJ));
    bus.card_in = 1'b0;
    step();

    insert_to_pin(4'd1);
    bus.pin_valid = 1'b1;
    bus.pin_in    = 16'd1234;
    step();
    bus.pin_valid = 1'b0;
    step();
    check("act_grant", 32'(bus.session_active), 1);
    for (int r = 0; r < 3; r++) begin
      repeat (9) begin
        step();
        check("act_quiet", 32'(pulses()), 0);
      end
      bus.activity = 1'b1;
      step();
      bus.activity = 1'b0;
      check("act_kept", 32'(bus.session_active), 1);
    end
    for (int c = 1; c < TMO; c++) begin
      step();
      check("act_no_timeout", 32'(pulses()), 0);
    end
    step();
    check("act_timeout", 32'(pulses()), 32'(P_TO | P_EJ));
    check("act_to_inactive", 32'(bus.session_active), 0);
    bus.card_in = 1'b0;
    step();

    insert_to_pin(4'd3);
    bus.pin_valid = 1'b1;
    bus.pin_in    = 16'd3456;
    step();
    bus.pin_valid = 1'b0;
    bus.card_in   = 1'b0;
    step();
    check("dchk_active", 32'(bus.session_active), 0);
    check("dchk_pin", 32'(bus.auth_pin), 0);
    check("dchk_tries", 32'(bus.tries_left), 0);
    check("dchk_pulses", 32'(pulses()), 0);

    insert_to_pin(4'd3);
    bus.pin_valid = 1'b1;
    bus.pin_in    = 16'd3456;
    step();
    bus.pin_valid = 1'b0;
    step();
    check("dact_grant", 32'(bus.session_active), 1);
    bus.card_in = 1'b0;
    step();
    check("dact_active", 32'(bus.session_active), 0);
    check("dact_pin", 32'(bus.auth_pin), 0);
    check("dact_tries", 32'(bus.tries_left), 0);
    check("dact_pulses", 32'(pulses()), 0);

    pv = '{16'd7, 16'd8, 16'd9};
    run_session(4'd3, 3, pv, 1'b0);
    insert_to_pin(4'd1);
    bus.pin_valid = 1'b1;
    bus.pin_in    = 16'd1234;
    step();
    bus.pin_valid = 1'b0;
    step();
    check("pre_rst_active", 32'(bus.session_active), 1);
    rst         = 1'b1;
    bus.card_in = 1'b0;
    step();
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < NACC; i++) lockm[i] = 1'b0;
    pv = '{16'd3456, 16'd0, 16'd0};
    run_session(4'd3, 1, pv, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        unlock(4'($urandom_range(0, 15)));
      end
      acc = 4'($urandom_range(0, 12));
      np  = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) begin
        if (acc >= 4'd1 && acc <= 4'd10 &&
            $urandom_range(0, 2) == 0) begin
          pv[k] = PINS[acc - 4'd1];
        end else begin
          pv[k] = 16'($urandom_range(0, 9999));
          if (acc >= 4'd1 && acc <= 4'd10 &&
              pv[k] == PINS[acc - 4'd1]) begin
            pv[k] = pv[k] + 16'd1;
          end
        end
      end
      run_session(acc, np, pv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/auth_session_ctrl.md
# auth_session_ctrl

Sequencing controller for the combinational account authenticator. Owns one ATM card session: captures the account number on card insertion, drives the authenticator's account/PIN inputs, samples its found/authenticated results, counts failed PIN attempts, locks accounts after too many failures, and enforces an entry/inactivity timeout. Sits between the card/keypad front end and the transaction logic, which it enables through `session_active`.

## Interface
Parameters:
- `MAX_TRIES`, default 3: PIN attempts allowed per session before the account is locked (1..3).
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed in WAIT_PIN and ACTIVE.
- `NUM_ACCOUNTS`, default 10: depth of the lock bitmap, indexed by authenticator account index.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `card_in` in 1: level signal, high while a card is inserted.
- `acc_num_in` in 4: account number from the card, valid when `card_in` is high.
- `pin_valid` in 1: one-cycle strobe qualifying `pin_in`.
- `pin_in` in 16: entered PIN, in decimal value.
- `activity` in 1: strobe from transaction logic that restarts the inactivity timer in ACTIVE.
- `logout` in 1: strobe that ends an active session.
- `unlock_req` in 1, `unlock_idx` in 4: admin strobe that clears lock bit `unlock_idx`.
- `auth_acc_num` out 4, `auth_pin` out 16: registered drive to the authenticator.
- `auth_acc_index` in 4, `auth_found` in 1, `auth_ok` in 1: authenticator results.
- `session_active` out 1: high in ACTIVE only.
- `session_index` out 4: account index of the current session, valid while `session_active` is high.
- `tries_left` out 2: remaining attempts.
- `not_found`, `pin_fail`, `locked`, `timeout`, `eject` out 1: one-cycle status pulses.

## Operation
States: IDLE, LOOKUP, WAIT_PIN, CHECK, ACTIVE, EJECT.

- **IDLE**: on `card_in`=1, latch `acc_num_in` into `auth_acc_num` and go to LOOKUP.
- **LOOKUP**: sample `auth_found` and `auth_acc_index`.
  - Not found: pulse `not_found`, go to EJECT.
  - Found and `lock[idx]`=1: pulse `locked`, go to EJECT.
  - Otherwise: store `session_index`, load `tries_left`=MAX_TRIES, clear the timer, go to WAIT_PIN.
- **WAIT_PIN**:
  - On `pin_valid`, latch `pin_in` into `auth_pin` and go to CHECK.
  - If the timer reaches TIMEOUT_CYCLES-1 first: pulse `timeout`, go to EJECT.
- **CHECK**: sample `auth_ok`.
  - `auth_ok`=1: go to ACTIVE, clear the timer.
  - `auth_ok`=0: decrement `tries_left`.
    - Result is 0: set `lock[session_index]`, pulse `locked`, go to EJECT.
    - Otherwise: pulse `pin_fail`, clear the timer, go to WAIT_PIN.
- **ACTIVE**:
  - `activity` clears the timer.
  - `logout` or timer expiry (expiry also pulses `timeout`) goes to EJECT.
- **EJECT**: pulse `eject` on entry. Clear `auth_pin` to 0. Stay until `card_in`=0, then go to IDLE.

Global rules:
- `card_in`=0 in any state other than IDLE/EJECT goes straight to IDLE. `session_active`, `auth_pin` and `tries_left` are cleared; no pulses are emitted.
- `pin_valid` is ignored outside WAIT_PIN. `logout` and `activity` are ignored outside ACTIVE.
- `unlock_req` applies in any state.
  - If it targets the same index in the same cycle as a lock-set, the set wins.
  - `unlock_idx` ≥ NUM_ACCOUNTS is ignored.
- The timer is a saturating counter of width clog2(TIMEOUT_CYCLES).

## Timing
- Reset values:
  - State IDLE; `auth_acc_num`=0, `auth_pin`=0, `session_index`=0, `tries_left`=0.
  - `session_active`=0; all pulses 0.
  - Lock bitmap all 0 (reset clears locks).
- Insertion to result: `card_in` high at edge N puts LOOKUP in effect with `auth_acc_num` valid after N. Results are sampled at N+1; the next state is in effect after N+1.
- PIN to verdict: `pin_valid` at edge M updates `auth_pin` after M. CHECK samples at M+1. `session_active` is high after M+1, so there are 2 cycles from strobe to session.
- All outputs are registered. Status pulses are high for exactly one cycle, coincident with the state transition they report.
- Timeout: exactly TIMEOUT_CYCLES cycles in WAIT_PIN or ACTIVE with no qualifying event produces `timeout`.

## Test plan
- Card acc 3 inserted, PIN 3456 → `session_active`=1 two cycles after `pin_valid`, `session_index`=2, `tries_left`=3; then `logout` → `eject` pulse, IDLE after `card_in` drops.
- Card acc 12 → `not_found` pulse one cycle after LOOKUP, `eject`, `session_active` stays 0.
- Card acc 5, PINs 1111, 2222, 3333 → `pin_fail` twice (`tries_left` 2 then 1), then `locked` with `lock[4]`=1. Reinsert acc 5 with correct PIN 5678 → `locked` at LOOKUP. `unlock_req` with idx 4, then reinsert and enter 5678 → session granted.
- Acc 1 with TIMEOUT_CYCLES=16 and no PIN → `timeout` exactly 16 cycles after entering WAIT_PIN. In ACTIVE, `activity` every 10 cycles → no timeout; then silence → `timeout` after 16 cycles.
- `card_in` dropped during CHECK and during ACTIVE → IDLE next cycle, `auth_pin`=0, no pulses.
- `rst` asserted mid-ACTIVE with `lock[2]` set → all outputs at reset values and the lock bitmap cleared on the next edge.
